// File: rtl/ald_recipe_sequencer_if.sv
// Operator-side and ladder-side signals of the ALD recipe sequencer.
interface ald_recipe_sequencer_if;
    logic       start_btn;
    logic       stop_btn;
    logic [7:0] cycles_req;
    logic       start_o;
    logic       stop_o;
    logic       tp1;
    logic       tp2;
    logic       tp3;
    logic       tr;
    logic       busy;
    logic       done;
    logic [7:0] cycle_count;

    modport master (
        output start_btn, stop_btn, cycles_req,
        input  start_o, stop_o, tp1, tp2, tp3, tr, busy, done, cycle_count
    );
    modport slave (
        input  start_btn, stop_btn, cycles_req,
        output start_o, stop_o, tp1, tp2, tp3, tr, busy, done, cycle_count
    );
endinterface

// File: rtl/ald_recipe_sequencer.sv
// ALD recipe sequencer: debounced start/stop buttons drive a timed
// dose/purge phase FSM that strobes a ladder controller.
module ald_btn_debounce #(
    parameter int DEB_TICKS = 16
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic          sync1, sync2, deb;
    logic [CW-1:0] cnt;

    // A new level is taken only after DEB_TICKS consecutive samples differ from the held level.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_TICKS - 1)) begin
                deb   <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ald_recipe_sequencer #(
    parameter int DEB_TICKS = 16,
    parameter int T_DOSE1   = 100,
    parameter int T_PURGE1  = 200,
    parameter int T_DOSE2   = 100,
    parameter int T_PURGE2  = 200
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    ald_recipe_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DOSE1, S_PURGE1, S_DOSE2, S_PURGE2, S_DONE, S_ABORT
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  btn_raw, press;
    logic        start_p, stop_p;
    logic [31:0] timer;
    logic [7:0]  req_q, cnt_q;
    logic        latch, cnt_inc, expired;

    assign btn_raw = {bus.stop_btn, bus.start_btn};
    assign start_p = press[0];
    assign stop_p  = press[1];

    ald_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_btn [1:0] (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .btn      (btn_raw),
        .press    (press)
    );

    function automatic logic [31:0] phase_len(state_t s);
        case (s)
            S_DOSE1:  phase_len = 32'(T_DOSE1 - 1);
            S_PURGE1: phase_len = 32'(T_PURGE1 - 1);
            S_DOSE2:  phase_len = 32'(T_DOSE2 - 1);
            S_PURGE2: phase_len = 32'(T_PURGE2 - 1);
            default:  phase_len = 32'd0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        cnt_inc   = 1'b0;
        expired   = (timer == 32'd0);
        // Stop outranks start and timer expiry everywhere outside IDLE.
        if (stop_p && state != S_IDLE) begin
            state_nxt = S_ABORT;
        end else begin
            case (state)
                S_IDLE: if (start_p && !stop_p) begin
                    latch     = 1'b1;
                    state_nxt = (bus.cycles_req == 8'd0) ? S_DONE : S_START;
                end
                S_START:  state_nxt = S_DOSE1;
                S_DOSE1:  if (expired) state_nxt = S_PURGE1;
                S_PURGE1: if (expired) state_nxt = S_DOSE2;
                S_DOSE2:  if (expired) state_nxt = S_PURGE2;
                S_PURGE2: if (expired) begin
                    cnt_inc   = 1'b1;
                    state_nxt = (cnt_q + 8'd1 == req_q) ? S_DONE : S_DOSE1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.cycle_count = cnt_q;

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= 32'd0;
            req_q       <= 8'd0;
            cnt_q       <= 8'd0;
            bus.start_o <= 1'b0;
            bus.stop_o  <= 1'b0;
            bus.tp1     <= 1'b0;
            bus.tp2     <= 1'b0;
            bus.tp3     <= 1'b0;
            bus.tr      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                req_q <= bus.cycles_req;
                cnt_q <= 8'd0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_nxt != state)    timer <= phase_len(state_nxt);
            else if (timer != 32'd0)   timer <= timer - 32'd1;
            bus.start_o <= (state_nxt == S_START);
            bus.stop_o  <= (state_nxt == S_ABORT) || (state == S_IDLE && stop_p);
            bus.tp1     <= (state_nxt == S_DOSE1);
            bus.tp2     <= (state_nxt == S_PURGE1);
            bus.tp3     <= (state_nxt == S_DOSE2);
            bus.tr      <= (state_nxt == S_PURGE2);
            bus.busy    <= (state_nxt == S_START) || (state_nxt == S_DOSE1) ||
                           (state_nxt == S_PURGE1) || (state_nxt == S_DOSE2) ||
                           (state_nxt == S_PURGE2);
            bus.done    <= (state_nxt == S_DONE);
        end
    end
endmodule
